// File: rtl/nn_classifier_core_if.sv
// Handshake and weight-programming bundle for nn_classifier_core.
// The slave modport is the core's view; the master modport is the
// environment (input FIFO, ID FIFO and weight loader) view.
`ifndef NN_ID_BUS
`define NN_ID_BUS 4
`endif

interface nn_classifier_core_if #(
  parameter int NUM_CLASSES = 4,
  parameter int WADDR_W     = $clog2(NUM_CLASSES)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_data;
  logic                   w_we;
  logic [WADDR_W-1:0]     w_addr;
  logic [31:0]            w_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [`NN_ID_BUS-1:0]  out_id;
  logic signed [17:0]     out_score;
  logic                   busy;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data, out_ready,
    input  in_ready, out_valid, out_id, out_score, busy
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data, out_ready,
    output in_ready, out_valid, out_id, out_score, busy
  );
endinterface

// File: rtl/nn_classifier_core.sv
// Single-layer int8 classifier: latches one word of four signed features,
// scores it against one weight row per cycle and presents the argmax class.
// Ties keep the lower class index; the result is held until accepted.
`ifndef NN_ID_BUS
`define NN_ID_BUS 4
`endif

module nn_classifier_core #(
  parameter int NUM_CLASSES = 4,
  parameter int WADDR_W     = $clog2(NUM_CLASSES)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  nn_classifier_core_if.slave bus
);

  localparam int ID_W = `NN_ID_BUS;

  // Class count must be addressable by the downstream ID bus.
  generate
    if (NUM_CLASSES < 2 || NUM_CLASSES > (1 << ID_W)) begin : g_bad_cfg
      $error("nn_classifier_core: NUM_CLASSES does not fit the ID bus");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WADDR_W-1:0]     cls_q, cls_d;
  logic [31:0]            feat_q, feat_d;
  logic [31:0]            w_q [NUM_CLASSES];
  logic signed [17:0]     best_score_q, best_score_d;
  logic [ID_W-1:0]        best_id_q, best_id_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic signed [17:0]     score_s;
  logic                   last_cls_s;
  logic                   w_hit_s;

  // Exact dot product of four signed bytes: 16-bit products, 18-bit sum.
  function automatic logic signed [17:0] dot4(input logic [31:0] f,
                                              input logic [31:0] w);
    logic signed [17:0] acc;
    logic signed [15:0] prod;
    acc = 18'sd0;
    for (int i = 0; i < 4; i++) begin
      prod = $signed(f[8*i +: 8]) * $signed(w[8*i +: 8]);
      acc  = acc + $signed({{2{prod[15]}}, prod});
    end
    return acc;
  endfunction

  assign score_s    = dot4(feat_q, w_q[cls_q]);
  assign last_cls_s = (32'(cls_q) == NUM_CLASSES - 1);
  assign w_hit_s    = bus.w_we && (32'(bus.w_addr) < NUM_CLASSES);

  // Next-state and datapath update for the IDLE/MAC/OUT sequence.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    feat_d       = feat_q;
    best_score_d = best_score_q;
    best_id_d    = best_id_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          feat_d       = bus.in_data;
          cls_d        = {WADDR_W{1'b0}};
          best_score_d = 18'sd0;
          best_id_d    = {ID_W{1'b0}};
          state_d      = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        // Strictly-greater comparison keeps the lower index on ties.
        if (cls_q == {WADDR_W{1'b0}} || score_s > best_score_q) begin
          best_score_d = score_s;
          best_id_d    = ID_W'(cls_q);
        end else begin
          best_score_d = best_score_q;
        end
        if (last_cls_s) begin
          state_d = ST_OUT;
        end else begin
          cls_d = cls_q + WADDR_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cls_q        <= {WADDR_W{1'b0}};
      feat_q       <= 32'h0000_0000;
      best_score_q <= 18'sd0;
      best_id_q    <= {ID_W{1'b0}};
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      feat_q       <= feat_d;
      best_score_q <= best_score_d;
      best_id_q    <= best_id_d;
      in_ready_q   <= (state_d == ST_IDLE);
      out_valid_q  <= (state_d == ST_OUT);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Weight file; a row written this cycle is seen by MAC from the next cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int r = 0; r < NUM_CLASSES; r++) begin
        w_q[r] <= 32'h0000_0000;
      end
    end else if (w_hit_s) begin
      w_q[bus.w_addr] <= bus.w_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = best_id_q;
  assign bus.out_score = best_score_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nn_classifier_core.sv
// Self-checking bench for nn_classifier_core: directed scenarios plus
// randomized words and weights against an arithmetic argmax model.
module tb_nn_classifier_core;

  localparam int NC = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  logic [31:0] wm [NC];

  nn_classifier_core_if #(.NUM_CLASSES(NC)) bus_if ();

  nn_classifier_core #(.NUM_CLASSES(NC)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: score every class with plain integer arithmetic, first max wins.
  function automatic void model_eval(input logic [31:0] f, output int id, output int sc);
    int s;
    id = 0;
    sc = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int i = 0; i < 4; i++)
        s += int'($signed(f[8*i +: 8])) * int'($signed(wm[c][8*i +: 8]));
      if (c == 0 || s > sc) begin
        sc = s;
        id = c;
      end
    end
  endfunction

  task automatic write_w(input int addr, input logic [31:0] data);
    bus_if.w_we   = 1'b1;
    bus_if.w_addr = addr[1:0];
    bus_if.w_data = data;
    @(negedge clk);
    bus_if.w_we = 1'b0;
    wm[addr] = data;
  endtask

  // Send one word (caller at a negedge), hold out_ready low for 'hold' cycles
  // once the result appears, then complete the handshake.
  task automatic run_word(input string tag, input logic [31:0] f, input int hold);
    int exp_id, exp_sc, lat, waitc;
    model_eval(f, exp_id, exp_sc);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = f;
    waitc = 0;
    while (!bus_if.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "_in_ready"}, bus_if.in_ready, 1);
    bus_if.out_ready = (hold == 0);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = $urandom();
    chk({tag, "_busy"}, bus_if.busy, 1);
    lat = 1;
    while (!bus_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_id"}, bus_if.out_id, exp_id);
    chk({tag, "_score"}, bus_if.out_score, exp_sc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus_if.out_valid, 1);
      chk({tag, "_hold_id"}, bus_if.out_id, exp_id);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_valid"}, bus_if.out_valid, 0);
    chk({tag, "_post_ready"}, bus_if.in_ready, 1);
  endtask

  initial begin
    int exp_id, exp_sc, cnt, seen;
    logic [31:0] f;
    n_total = 0;
    n_bad   = 0;
    for (int c = 0; c < NC; c++) wm[c] = 32'h0;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 32'h0;
    bus_if.w_we      = 1'b0;
    bus_if.w_addr    = 2'd0;
    bus_if.w_data    = 32'h0;
    bus_if.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_out_id", bus_if.out_id, 0);
    chk("rst_out_score", bus_if.out_score, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", bus_if.in_ready, 1);

    // All-zero weights after reset.
    run_word("zero_w", 32'h7F80_1234, 0);

    // Basic and ties/negatives.
    write_w(0, 32'h0101_0101);
    write_w(1, 32'h0202_0202);
    write_w(2, 32'h0000_0000);
    write_w(3, 32'h0000_0000);
    run_word("basic", 32'h0101_0101, 0);
    chk("basic_id_const", bus_if.out_id, 1);
    run_word("ties", 32'hFFFF_FFFF, 0);

    // Extremes.
    write_w(0, 32'h8080_8080);
    write_w(1, 32'h0000_0000);
    run_word("ext_max", 32'h8080_8080, 0);
    write_w(0, 32'h7F7F_7F7F);
    run_word("ext_min", 32'h8080_8080, 0);

    // Backpressure with in_valid held high; next word follows the handshake.
    write_w(0, 32'h0102_0304);
    write_w(2, 32'hFF00_7F01);
    f = 32'h1122_8344;
    model_eval(f, exp_id, exp_sc);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = f;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    bus_if.in_data = 32'h0505_0505;
    cnt = 1;
    while (!bus_if.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_latency", cnt, 5);
    for (int h = 0; h < 10; h++) begin
      chk("bp_valid", bus_if.out_valid, 1);
      chk("bp_id", bus_if.out_id, exp_id);
      chk("bp_score", bus_if.out_score, exp_sc);
      chk("bp_in_ready", bus_if.in_ready, 0);
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", bus_if.out_valid, 0);
    chk("bp_idle_ready", bus_if.in_ready, 1);
    model_eval(32'h0505_0505, exp_id, exp_sc);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    chk("bp_next_busy", bus_if.busy, 1);
    cnt = 1;
    while (!bus_if.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_next_latency", cnt, 5);
    chk("bp_next_id", bus_if.out_id, exp_id);
    chk("bp_next_score", bus_if.out_score, exp_sc);
    @(negedge clk);

    // Weight write in the cycle MAC reads class 1.
    write_w(0, 32'h0101_0101);
    write_w(1, 32'h0202_0202);
    write_w(2, 32'h0000_0000);
    write_w(3, 32'h0000_0000);
    f = 32'h0101_0101;
    model_eval(f, exp_id, exp_sc);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = f;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    write_w(1, 32'h0000_0000);
    cnt = 0;
    while (!bus_if.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("wdur_id_old", bus_if.out_id, exp_id);
    chk("wdur_score_old", bus_if.out_score, exp_sc);
    @(negedge clk);
    run_word("wdur_new", f, 0);

    // Reset in the second MAC cycle.
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h7F7F_7F7F;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", bus_if.in_ready, 0);
    chk("mrst_busy", bus_if.busy, 0);
    rst = 1'b0;
    for (int c = 0; c < NC; c++) wm[c] = 32'h0;
    seen = 0;
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen++;
    end
    chk("mrst_no_valid", seen, 0);
    chk("mrst_in_ready_rel", bus_if.in_ready, 1);
    run_word("mrst_zero", 32'h8081_7F7E, 0);

    // Randomized weights, words and backpressure.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(1, 0) == 1) write_w($urandom_range(NC - 1, 0), $urandom());
      end
      run_word("rand", $urandom(), $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
